// File: rtl/dig_in_event_capture_if.sv
// Register bus shared with the digital-input app: 8-bit address, 16-bit data,
// one-cycle read/write strobes and a registered read return.
interface dig_in_event_capture_if;
   logic        write_qualified;
   logic        read_qualified;
   logic [7:0]  ab;
   logic [15:0] db_in;
   logic [15:0] db_out_DIGE;
   logic        data_from_DIGE_avail;

   modport master (
      output write_qualified, read_qualified, ab, db_in,
      input  db_out_DIGE, data_from_DIGE_avail
   );

   modport slave (
      input  write_qualified, read_qualified, ab, db_in,
      output db_out_DIGE, data_from_DIGE_avail
   );
endinterface

// File: rtl/dig_in_event_capture.sv
// Edge capture on the debounced input word: sticky rise/fall latches, one selectable
// channel feeding a saturating counter and tick timestamp, and a maskable interrupt.
module dig_in_event_capture #(
   parameter logic [15:0] PRESCALE = 16'd1000
) (
   input  logic                         xclk,
   input  logic                         reset,
   dig_in_event_capture_if.slave        bus,
   input  logic [15:0]                  dig_in_debounced,
   output logic                         irq_dig_event
);

   localparam logic [7:0] ADDR_RISE   = 8'h40;
   localparam logic [7:0] ADDR_FALL   = 8'h41;
   localparam logic [7:0] ADDR_CFG    = 8'h42;
   localparam logic [7:0] ADDR_COUNT  = 8'h43;
   localparam logic [7:0] ADDR_TSTAMP = 8'h44;
   localparam logic [7:0] ADDR_MASK   = 8'h45;

   logic [15:0] dig_in_p1;
   logic        armed;
   logic [15:0] rise_lat, fall_lat;
   logic [15:0] mask;
   logic [3:0]  chan;
   logic [1:0]  mode;
   logic [15:0] count, tstamp;
   logic [15:0] prescale_cnt, tick;

   logic [15:0] rise_edge, fall_edge;
   logic        rd_rise, rd_fall;
   logic        wr_cfg, wr_count, wr_mask;
   logic        counted;
   logic [15:0] rd_data;
   logic        rd_hit;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      rise_edge = armed ? (dig_in_debounced & ~dig_in_p1) : 16'h0000;
      fall_edge = armed ? (~dig_in_debounced & dig_in_p1) : 16'h0000;
      rd_rise   = bus.read_qualified  && (bus.ab == ADDR_RISE);
      rd_fall   = bus.read_qualified  && (bus.ab == ADDR_FALL);
      wr_cfg    = bus.write_qualified && (bus.ab == ADDR_CFG);
      wr_count  = bus.write_qualified && (bus.ab == ADDR_COUNT);
      wr_mask   = bus.write_qualified && (bus.ab == ADDR_MASK);
      counted   = (mode[0] && rise_edge[chan]) || (mode[1] && fall_edge[chan]);
   end

   always_comb begin
      rd_data = 16'hFFFF;
      rd_hit  = 1'b1;
      case (bus.ab)
         ADDR_RISE:   rd_data = rise_lat;
         ADDR_FALL:   rd_data = fall_lat;
         ADDR_CFG:    rd_data = {10'b0, mode, chan};
         ADDR_COUNT:  rd_data = count;
         ADDR_TSTAMP: rd_data = tstamp;
         ADDR_MASK:   rd_data = mask;
         default:     rd_hit  = 1'b0;
      endcase
   end

   // Stage p1: previous input sample; the first cycle after reset only arms detection
   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) begin
         dig_in_p1 <= 16'h0000;
         armed     <= 1'b0;
      end else begin
         dig_in_p1 <= dig_in_debounced;
         armed     <= 1'b1;
      end
   end

   // A new edge overrides the clear-on-read in the same cycle
   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) begin
         rise_lat <= 16'h0000;
         fall_lat <= 16'h0000;
      end else begin
         rise_lat <= (rise_lat & ~{16{rd_rise}}) | rise_edge;
         fall_lat <= (fall_lat & ~{16{rd_fall}}) | fall_edge;
      end
   end

   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) begin
         chan <= 4'h0;
         mode <= 2'b00;
         mask <= 16'h0000;
      end else begin
         if (wr_cfg) begin
            chan <= bus.db_in[3:0];
            mode <= bus.db_in[5:4];
         end
         if (wr_mask)
            mask <= bus.db_in;
      end
   end

   // Register clears take priority over a coincident counted edge
   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) begin
         count  <= 16'h0000;
         tstamp <= 16'h0000;
      end else if (wr_cfg) begin
         count  <= 16'h0000;
         tstamp <= 16'h0000;
      end else begin
         if (wr_count)
            count <= 16'h0000;
         else if (counted)
            count <= sat_inc(count);
         if (counted)
            tstamp <= tick;
      end
   end

   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) begin
         prescale_cnt <= 16'h0000;
         tick         <= 16'h0000;
      end else if (prescale_cnt == PRESCALE - 16'd1) begin
         prescale_cnt <= 16'h0000;
         tick         <= tick + 16'd1;
      end else begin
         prescale_cnt <= prescale_cnt + 16'd1;
      end
   end

   // Stage p1: registered read return, held while no read strobe is present
   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) begin
         bus.db_out_DIGE          <= 16'h0000;
         bus.data_from_DIGE_avail <= 1'b0;
      end else if (bus.read_qualified) begin
         bus.db_out_DIGE          <= rd_data;
         bus.data_from_DIGE_avail <= rd_hit;
      end
   end

   always_ff @(posedge xclk or negedge reset) begin
      if (!reset)
         irq_dig_event <= 1'b0;
      else
         irq_dig_event <= |((rise_lat | fall_lat) & mask);
   end

endmodule

// File: tb/tb_dig_in_event_capture.sv
// Bench for dig_in_event_capture: two instances (PRESCALE 4 and 1) share one stimulus
// stream; a cycle model is compared every cycle, plus hand-computed directed reads.
module tb_dig_in_event_capture;

   logic        xclk  = 1'b0;
   logic        reset = 1'b1;
   logic        wq = 1'b0, rq = 1'b0;
   logic [7:0]  ab = 8'h00;
   logic [15:0] dbi = 16'h0000;
   logic [15:0] din = 16'h0000;
   logic        irq0, irq1;
   int          errors = 0;
   int          checks = 0;
   bit          chk_en = 1'b0;

   dig_in_event_capture_if bus0 ();
   dig_in_event_capture_if bus1 ();

   assign bus0.write_qualified = wq;
   assign bus0.read_qualified  = rq;
   assign bus0.ab              = ab;
   assign bus0.db_in           = dbi;
   assign bus1.write_qualified = wq;
   assign bus1.read_qualified  = rq;
   assign bus1.ab              = ab;
   assign bus1.db_in           = dbi;

   dig_in_event_capture #(.PRESCALE(16'd4)) dut0 (
      .xclk(xclk), .reset(reset), .bus(bus0),
      .dig_in_debounced(din), .irq_dig_event(irq0)
   );
   dig_in_event_capture #(.PRESCALE(16'd1)) dut1 (
      .xclk(xclk), .reset(reset), .bus(bus1),
      .dig_in_debounced(din), .irq_dig_event(irq1)
   );

   always #5 xclk = ~xclk;

   // Behavioural model: tick is derived from the number of clocks since reset release
   logic [15:0] m_prev, m_rise, m_fall, m_mask, m_count;
   logic [15:0] m_ts [2];
   logic [15:0] m_db [2];
   logic [3:0]  m_chan;
   logic [1:0]  m_mode;
   logic        m_armed, m_avail, m_irq;
   int          m_n;

   function automatic int ps(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   initial begin : model
      logic [15:0] er, ef;
      logic        cnt;
      forever begin
         @(posedge xclk or negedge reset);
         if (!reset) begin
            m_prev = 16'h0; m_rise = 16'h0; m_fall = 16'h0; m_mask = 16'h0; m_count = 16'h0;
            m_chan = 4'h0; m_mode = 2'b00; m_armed = 1'b0; m_avail = 1'b0; m_irq = 1'b0;
            m_n = 0;
            for (int d = 0; d < 2; d++) begin m_ts[d] = 16'h0; m_db[d] = 16'h0; end
         end else begin
            er = m_armed ? (din & ~m_prev) : 16'h0;
            ef = m_armed ? (~din & m_prev) : 16'h0;
            if (rq) begin
               m_avail = 1'b1;
               for (int d = 0; d < 2; d++) begin
                  case (ab)
                     8'h40: m_db[d] = m_rise;
                     8'h41: m_db[d] = m_fall;
                     8'h42: m_db[d] = {10'b0, m_mode, m_chan};
                     8'h43: m_db[d] = m_count;
                     8'h44: m_db[d] = m_ts[d];
                     8'h45: m_db[d] = m_mask;
                     default: begin m_db[d] = 16'hFFFF; m_avail = 1'b0; end
                  endcase
               end
            end
            m_irq  = |((m_rise | m_fall) & m_mask);
            m_rise = ((rq && ab == 8'h40) ? 16'h0 : m_rise) | er;
            m_fall = ((rq && ab == 8'h41) ? 16'h0 : m_fall) | ef;
            cnt = (m_mode[0] && er[m_chan]) || (m_mode[1] && ef[m_chan]);
            if (wq && ab == 8'h42) begin
               m_count = 16'h0;
               for (int d = 0; d < 2; d++) m_ts[d] = 16'h0;
            end else begin
               if (wq && ab == 8'h43) m_count = 16'h0;
               else if (cnt && m_count != 16'hFFFF) m_count = m_count + 16'd1;
               if (cnt)
                  for (int d = 0; d < 2; d++) m_ts[d] = 16'((m_n / ps(d)) % 65536);
            end
            if (wq && ab == 8'h42) begin m_chan = dbi[3:0]; m_mode = dbi[5:4]; end
            if (wq && ab == 8'h45) m_mask = dbi;
            m_prev  = din;
            m_armed = 1'b1;
            m_n     = m_n + 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge xclk) begin
      if (chk_en) begin
         chk("cyc_db0",  bus0.db_out_DIGE, m_db[0]);
         chk("cyc_db1",  bus1.db_out_DIGE, m_db[1]);
         chk("cyc_av0",  {15'b0, bus0.data_from_DIGE_avail}, {15'b0, m_avail});
         chk("cyc_av1",  {15'b0, bus1.data_from_DIGE_avail}, {15'b0, m_avail});
         chk("cyc_irq0", {15'b0, irq0}, {15'b0, m_irq});
         chk("cyc_irq1", {15'b0, irq1}, {15'b0, m_irq});
      end
   end

   task automatic step();
      @(posedge xclk);
      #1;
   endtask

   task automatic set_din(input logic [15:0] v);
      din = v;
      step();
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
      wq = 1'b1; ab = a; dbi = d;
      step();
      wq = 1'b0;
   endtask

   task automatic rd_expect(input string nm, input logic [7:0] a, input logic [15:0] e0,
                            input logic [15:0] e1, input logic ea);
      rq = 1'b1; ab = a;
      step();
      rq = 1'b0;
      chk({nm, "_d0"}, bus0.db_out_DIGE, e0);
      chk({nm, "_d1"}, bus1.db_out_DIGE, e1);
      chk({nm, "_av"}, {15'b0, bus0.data_from_DIGE_avail}, {15'b0, ea});
   endtask

   task automatic chk_irq(input string nm, input logic e);
      chk({nm, "_0"}, {15'b0, irq0}, {15'b0, e});
      chk({nm, "_1"}, {15'b0, irq1}, {15'b0, e});
   endtask

   initial begin
      #1 reset = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("rst_db", bus0.db_out_DIGE, 16'h0000);
      chk("rst_av", {15'b0, bus0.data_from_DIGE_avail}, 16'h0000);
      chk_irq("rst_irq", 1'b0);

      // Input high through reset release: nothing latched
      din = 16'hFFFF;
      step(); step();
      reset = 1'b1;
      step();
      rd_expect("t1_rise", 8'h40, 16'h0000, 16'h0000, 1'b1);

      // Clear-on-read and set-wins-over-clear
      set_din(16'h0000);
      set_din(16'h0008);
      rd_expect("t2_rise_a", 8'h40, 16'h0008, 16'h0008, 1'b1);
      rd_expect("t2_rise_b", 8'h40, 16'h0000, 16'h0000, 1'b1);
      rd_expect("t2_fall_a", 8'h41, 16'hFFFF, 16'hFFFF, 1'b1);
      rd_expect("t2_fall_b", 8'h41, 16'h0000, 16'h0000, 1'b1);
      set_din(16'h0000);
      set_din(16'h0008);
      din = 16'h0028;
      rd_expect("t2_rise_c", 8'h40, 16'h0008, 16'h0008, 1'b1);
      rd_expect("t2_rise_d", 8'h40, 16'h0020, 16'h0020, 1'b1);
      rd_expect("t2_fall_c", 8'h41, 16'h0008, 16'h0008, 1'b1);

      // Fresh reset: timestamp, counter, saturation, tick wrap on the PRESCALE=1 copy
      din = 16'h0000;
      step();
      reset = 1'b0;
      step(); step();
      reset = 1'b1;
      bus_write(8'h42, 16'h0012);
      repeat (39) step();
      set_din(16'h0004);
      rd_expect("t4_tstamp", 8'h44, 16'h000A, 16'h0028, 1'b1);

      bus_write(8'h42, 16'h0037);
      repeat (5) begin din = din ^ 16'h0080; step(); end
      rd_expect("t3_count5", 8'h43, 16'h0005, 16'h0005, 1'b1);
      rd_expect("t3_cfg",    8'h42, 16'h0037, 16'h0037, 1'b1);
      bus_write(8'h43, 16'h1234);
      rd_expect("t3_count0", 8'h43, 16'h0000, 16'h0000, 1'b1);
      for (int i = 0; i < 65540; i++) begin din = din ^ 16'h0080; step(); end
      rd_expect("t3_sat",    8'h43, 16'hFFFF, 16'hFFFF, 1'b1);
      rd_expect("t4_wrap",   8'h44, 16'h400D, 16'h0037, 1'b1);
      din = din ^ 16'h0080;
      bus_write(8'h43, 16'h0000);
      rd_expect("t3_clrwin", 8'h43, 16'h0000, 16'h0000, 1'b1);

      // Interrupt masking
      rd_expect("t5_rise_clr", 8'h40, 16'h0084, 16'h0084, 1'b1);
      rd_expect("t5_fall_clr", 8'h41, 16'h0080, 16'h0080, 1'b1);
      bus_write(8'h45, 16'h0001);
      set_din(din | 16'h0002);
      step();
      chk_irq("t5_irq_masked", 1'b0);
      set_din(din | 16'h0001);
      chk_irq("t5_irq_lat", 1'b0);
      step();
      chk_irq("t5_irq_set", 1'b1);
      rd_expect("t5_rise", 8'h40, 16'h0003, 16'h0003, 1'b1);
      rd_expect("t5_fall", 8'h41, 16'h0000, 16'h0000, 1'b1);
      chk_irq("t5_irq_clr", 1'b0);
      rd_expect("t5_mask", 8'h45, 16'h0001, 16'h0001, 1'b1);
      rd_expect("t5_bad",  8'h50, 16'hFFFF, 16'hFFFF, 1'b0);

      // Asynchronous reset in the middle of counting
      bus_write(8'h45, 16'hFFFF);
      bus_write(8'h42, 16'h0037);
      repeat (3) begin din = din ^ 16'h0080; step(); end
      rd_expect("t6_count3", 8'h43, 16'h0003, 16'h0003, 1'b1);
      chk_irq("t6_irq_pre", 1'b1);
      reset = 1'b0;
      #1;
      chk("t6_db",  bus0.db_out_DIGE, 16'h0000);
      chk("t6_av",  {15'b0, bus0.data_from_DIGE_avail}, 16'h0000);
      chk_irq("t6_irq", 1'b0);
      step(); step();
      reset = 1'b1;
      rd_expect("t6_cfg",    8'h42, 16'h0000, 16'h0000, 1'b1);
      rd_expect("t6_count",  8'h43, 16'h0000, 16'h0000, 1'b1);
      rd_expect("t6_rise",   8'h40, 16'h0000, 16'h0000, 1'b1);
      rd_expect("t6_mask",   8'h45, 16'h0000, 16'h0000, 1'b1);
      rd_expect("t6_tstamp", 8'h44, 16'h0000, 16'h0000, 1'b1);
      bus_write(8'h42, 16'h0037);
      repeat (2) begin din = din ^ 16'h0080; step(); end
      rd_expect("t6_resume", 8'h43, 16'h0002, 16'h0002, 1'b1);

      step();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
